// File: rtl/cal_pkg.sv
// Shared definitions for the calendar/display block: mode encoding, the 7-segment
// glyph table and BCD calendar helpers (leap test, days-in-month, BCD increments).
package cal_pkg;

  localparam logic [1:0] MODE_RUN   = 2'd0;
  localparam logic [1:0] MODE_SET_Y = 2'd1;
  localparam logic [1:0] MODE_SET_M = 2'd2;
  localparam logic [1:0] MODE_SET_D = 2'd3;

  typedef enum logic [1:0] {
    StRun  = 2'd0,
    StSetY = 2'd1,
    StSetM = 2'd2,
    StSetD = 2'd3
  } mode_e;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Segments abcdefg, active-high; anything outside 0..9 is blank.
  function automatic logic [6:0] seg_glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = 7'b1111110;
      4'd1:    g = 7'b0110000;
      4'd2:    g = 7'b1101101;
      4'd3:    g = 7'b1111001;
      4'd4:    g = 7'b0110011;
      4'd5:    g = 7'b1011011;
      4'd6:    g = 7'b1011111;
      4'd7:    g = 7'b1110000;
      4'd8:    g = 7'b1111111;
      4'd9:    g = 7'b1111011;
      default: g = SEG_BLANK;
    endcase
    return g;
  endfunction

  // Two BCD digits divisible by 4: even tens need units 0/4/8, odd tens need 2/6.
  function automatic logic div4_bcd(input logic [3:0] tens, input logic [3:0] units);
    if (tens[0]) return (units == 4'd2) || (units == 4'd6);
    return (units == 4'd0) || (units == 4'd4) || (units == 4'd8);
  endfunction

  function automatic logic is_leap_bcd(input logic [15:0] y);
    logic by4, by100, by400;
    by4   = div4_bcd(y[7:4], y[3:0]);
    by100 = (y[7:0] == 8'h00);
    by400 = by100 && div4_bcd(y[15:12], y[11:8]);
    return by4 && (!by100 || by400);
  endfunction

  function automatic logic [7:0] dim_bcd(input logic [7:0] month, input logic leap);
    logic [7:0] r;
    case (month)
      8'h02:                      r = leap ? 8'h29 : 8'h28;
      8'h04, 8'h06, 8'h09, 8'h11: r = 8'h30;
      default:                    r = 8'h31;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] bcd2_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [15:0] bcd4_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [15:0] to_bcd4(input int unsigned v);
    return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

endpackage

// File: rtl/seg7_scan_mux.sv
// Digit scanner: free-running prescaler; the digit select steps down once per
// prescaler wrap, from DIGITS-1 to 0 and back to DIGITS-1.
module seg7_scan_mux #(
  parameter int unsigned DIGITS   = 6,
  parameter int unsigned SCAN_DIV = 15
) (
  input  logic       clk,
  input  logic       reset,
  output logic [2:0] seg7_sel
);

  localparam logic [2:0] SelLast = 3'(DIGITS - 1);

  logic [SCAN_DIV-1:0] presc_q;
  logic [2:0]          sel_q;

  // Prescaler and digit select.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
      sel_q   <= SelLast;
    end else begin
      presc_q <= presc_q + SCAN_DIV'(1);
      if (&presc_q) begin
        sel_q <= (sel_q == 3'd0) ? SelLast : sel_q - 3'd1;
      end
    end
  end

  assign seg7_sel = sel_q;

endmodule

// File: rtl/calendar_set_display.sv
// BCD calendar with button-driven set mode and a multiplexed 7-segment display.
// Optional feature macro CAL_BLINK_EN: blanks the field being edited on a slow blink.
module calendar_set_display
  import cal_pkg::*;
#(
  parameter int unsigned YEAR_MIN = 2000,
  parameter int unsigned YEAR_MAX = 2099,
  parameter int unsigned DIGITS   = 6,
  parameter int unsigned SCAN_DIV = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick_day,
  input  logic        btn_mode,
  input  logic        btn_inc,
  output logic [1:0]  mode,
  output logic [15:0] year_bcd,
  output logic [7:0]  month_bcd,
  output logic [7:0]  day_bcd,
  output logic        year_wrap,
  output logic [2:0]  seg7_sel,
  output logic [6:0]  seg7_out,
  output logic        dpt_out
);

  localparam logic [15:0] YearMinBcd = to_bcd4(YEAR_MIN);
  localparam logic [15:0] YearMaxBcd = to_bcd4(YEAR_MAX);
  // 6-digit layout drops the two leading year digits of the 8-digit map.
  localparam logic [2:0]  PosOffset  = 3'(8 - DIGITS);

  mode_e       mode_q, mode_d;
  logic [15:0] year_q, year_d;
  logic [7:0]  month_q, month_d, day_q, day_d;
  logic        wrap_q, wrap_d;

  logic        leap_cur;
  logic [7:0]  dim_cur, dim_set_y, dim_set_m;
  logic [15:0] year_next;
  logic [7:0]  month_next;

  assign leap_cur   = is_leap_bcd(year_q);
  assign dim_cur    = dim_bcd(month_q, leap_cur);
  assign year_next  = (year_q == YearMaxBcd) ? YearMinBcd : bcd4_inc(year_q);
  assign month_next = (month_q == 8'h12) ? 8'h01 : bcd2_inc(month_q);
  assign dim_set_y  = dim_bcd(month_q, is_leap_bcd(year_next));
  assign dim_set_m  = dim_bcd(month_next, leap_cur);

  // Mode FSM next state: btn_mode cycles RUN -> SET_Y -> SET_M -> SET_D -> RUN.
  always_comb begin
    mode_d = mode_q;
    if (btn_mode) begin
      unique case (mode_q)
        StRun:  mode_d = StSetY;
        StSetY: mode_d = StSetM;
        StSetM: mode_d = StSetD;
        StSetD: mode_d = StRun;
        default: mode_d = StRun;
      endcase
    end
  end

  // Date next state: day ticks in RUN, field increments (inc dropped under btn_mode) in SET.
  always_comb begin
    year_d  = year_q;
    month_d = month_q;
    day_d   = day_q;
    wrap_d  = 1'b0;
    if (mode_q == StRun) begin
      if (tick_day) begin
        if (day_q < dim_cur) begin
          day_d = bcd2_inc(day_q);
        end else begin
          day_d = 8'h01;
          if (month_q == 8'h12) begin
            month_d = 8'h01;
            year_d  = year_next;
            wrap_d  = (year_q == YearMaxBcd);
          end else begin
            month_d = bcd2_inc(month_q);
          end
        end
      end
    end else if (btn_inc && !btn_mode) begin
      case (mode_q)
        StSetY: begin
          year_d = year_next;
          if (day_q > dim_set_y) day_d = dim_set_y;
        end
        StSetM: begin
          month_d = month_next;
          if (day_q > dim_set_m) day_d = dim_set_m;
        end
        StSetD:  day_d = (day_q >= dim_cur) ? 8'h01 : bcd2_inc(day_q);
        default: ;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q  <= StRun;
      year_q  <= YearMinBcd;
      month_q <= 8'h01;
      day_q   <= 8'h01;
      wrap_q  <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      year_q  <= year_d;
      month_q <= month_d;
      day_q   <= day_d;
      wrap_q  <= wrap_d;
    end
  end

  assign mode      = mode_q;
  assign year_bcd  = year_q;
  assign month_bcd = month_q;
  assign day_bcd   = day_q;
  assign year_wrap = wrap_q;

  seg7_scan_mux #(
    .DIGITS  (DIGITS),
    .SCAN_DIV(SCAN_DIV)
  ) u_scan (
    .clk     (clk),
    .reset   (reset),
    .seg7_sel(seg7_sel)
  );

  logic blink_q;
`ifdef CAL_BLINK_EN
  logic [SCAN_DIV+6:0] blink_cnt_q;

  // Blink phase: toggles every 2^(SCAN_DIV+7) clocks.
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_q + (SCAN_DIV + 7)'(1);
      if (&blink_cnt_q) blink_q <= ~blink_q;
    end
  end
`else
  assign blink_q = 1'b0;
`endif

  logic [2:0] pos;
  logic [3:0] digit;
  logic [1:0] digit_field;
  logic       blank;

  assign pos = seg7_sel + PosOffset;

  // Digit select in 8-digit terms: YYYY MM DD, left to right.
  always_comb begin
    digit       = 4'hf;
    digit_field = MODE_RUN;
    case (pos)
      3'd0: begin digit = year_q[15:12]; digit_field = MODE_SET_Y; end
      3'd1: begin digit = year_q[11:8];  digit_field = MODE_SET_Y; end
      3'd2: begin digit = year_q[7:4];   digit_field = MODE_SET_Y; end
      3'd3: begin digit = year_q[3:0];   digit_field = MODE_SET_Y; end
      3'd4: begin digit = month_q[7:4];  digit_field = MODE_SET_M; end
      3'd5: begin digit = month_q[3:0];  digit_field = MODE_SET_M; end
      3'd6: begin digit = day_q[7:4];    digit_field = MODE_SET_D; end
      default: begin digit = day_q[3:0]; digit_field = MODE_SET_D; end
    endcase
  end

  assign blank    = blink_q && (digit_field == mode);
  assign seg7_out = blank ? SEG_BLANK : seg_glyph(digit);
  assign dpt_out  = !blank && ((pos == 3'd3) || (pos == 3'd5));

endmodule

// File: tb/tb_calendar_set_display.sv
// Self-checking bench: two instances (6-digit default build, 8-digit fast-scan with
// YEAR_MAX 2199) driven against an integer calendar model through a scoreboard.
module tb_calendar_set_display;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [1:0] tick_v, bm_v, bi_v;

  logic [1:0]  mode_o  [2];
  logic [15:0] year_o  [2];
  logic [7:0]  month_o [2];
  logic [7:0]  day_o   [2];
  logic        wrap_o  [2];
  logic [2:0]  sel_o   [2];
  logic [6:0]  seg_o   [2];
  logic        dpt_o   [2];

  calendar_set_display #(
    .YEAR_MIN(2000), .YEAR_MAX(2099), .DIGITS(6), .SCAN_DIV(15)
  ) dut_a (
    .clk(clk), .reset(reset), .tick_day(tick_v[0]), .btn_mode(bm_v[0]), .btn_inc(bi_v[0]),
    .mode(mode_o[0]), .year_bcd(year_o[0]), .month_bcd(month_o[0]), .day_bcd(day_o[0]),
    .year_wrap(wrap_o[0]), .seg7_sel(sel_o[0]), .seg7_out(seg_o[0]), .dpt_out(dpt_o[0])
  );

  calendar_set_display #(
    .YEAR_MIN(2000), .YEAR_MAX(2199), .DIGITS(8), .SCAN_DIV(2)
  ) dut_b (
    .clk(clk), .reset(reset), .tick_day(tick_v[1]), .btn_mode(bm_v[1]), .btn_inc(bi_v[1]),
    .mode(mode_o[1]), .year_bcd(year_o[1]), .month_bcd(month_o[1]), .day_bcd(day_o[1]),
    .year_wrap(wrap_o[1]), .seg7_sel(sel_o[1]), .seg7_out(seg_o[1]), .dpt_out(dpt_o[1])
  );

  int checks = 0;
  int failures = 0;

  int m_y[2], m_m[2], m_d[2], m_mode[2];
  int y_min[2] = '{2000, 2000};
  int y_max[2] = '{2099, 2199};

  typedef struct {
    int id;
    int mode;
    int y;
    int m;
    int d;
    int wrap;
  } exp_t;

  exp_t sbq[$];

  function automatic bit leap(input int y);
    return (y % 4 == 0) && ((y % 100 != 0) || (y % 400 == 0));
  endfunction

  function automatic int dim(input int y, input int m);
    case (m)
      2:           return leap(y) ? 29 : 28;
      4, 6, 9, 11: return 30;
      default:     return 31;
    endcase
  endfunction

  function automatic logic [15:0] bcd4(input int v);
    return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [7:0] bcd2(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] glyph(input int d);
    case (d)
      0: return 7'b1111110;
      1: return 7'b0110000;
      2: return 7'b1101101;
      3: return 7'b1111001;
      4: return 7'b0110011;
      5: return 7'b1011011;
      6: return 7'b1011111;
      7: return 7'b1110000;
      8: return 7'b1111111;
      9: return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  // Digit at 8-digit position p (YYYYMMDD) of the model date of instance id.
  function automatic int model_digit(input int id, input int p);
    case (p)
      0: return m_y[id] / 1000;
      1: return (m_y[id] / 100) % 10;
      2: return (m_y[id] / 10) % 10;
      3: return m_y[id] % 10;
      4: return m_m[id] / 10;
      5: return m_m[id] % 10;
      6: return m_d[id] / 10;
      default: return m_d[id] % 10;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_y[i] = y_min[i];
      m_m[i] = 1;
      m_d[i] = 1;
      m_mode[i] = 0;
    end
  endtask

  // One clock of stimulus on instance id; the model's expected state is queued for the monitor.
  task automatic cyc(input int id, input bit t, input bit b_m, input bit b_i);
    exp_t e;
    int   wrap;
    @(negedge clk);
    tick_v[id] = t;
    bm_v[id]   = b_m;
    bi_v[id]   = b_i;
    wrap = 0;
    if (m_mode[id] == 0 && t) begin
      if (m_d[id] < dim(m_y[id], m_m[id])) begin
        m_d[id]++;
      end else begin
        m_d[id] = 1;
        if (m_m[id] == 12) begin
          m_m[id] = 1;
          if (m_y[id] == y_max[id]) begin
            m_y[id] = y_min[id];
            wrap = 1;
          end else begin
            m_y[id]++;
          end
        end else begin
          m_m[id]++;
        end
      end
    end
    if (b_m) begin
      m_mode[id] = (m_mode[id] + 1) % 4;
    end else if (b_i) begin
      case (m_mode[id])
        1: begin
          m_y[id] = (m_y[id] == y_max[id]) ? y_min[id] : m_y[id] + 1;
          if (m_d[id] > dim(m_y[id], m_m[id])) m_d[id] = dim(m_y[id], m_m[id]);
        end
        2: begin
          m_m[id] = (m_m[id] == 12) ? 1 : m_m[id] + 1;
          if (m_d[id] > dim(m_y[id], m_m[id])) m_d[id] = dim(m_y[id], m_m[id]);
        end
        3: m_d[id] = (m_d[id] >= dim(m_y[id], m_m[id])) ? 1 : m_d[id] + 1;
        default: ;
      endcase
    end
    e.id = id;
    e.mode = m_mode[id];
    e.y = m_y[id];
    e.m = m_m[id];
    e.d = m_d[id];
    e.wrap = wrap;
    @(posedge clk);
    #1;
    tick_v = '0;
    bm_v   = '0;
    bi_v   = '0;
    sbq.push_back(e);
  endtask

  // Scoreboard monitor: registered state is stable at the falling edge.
  always @(negedge clk) begin : sb_monitor
    exp_t e;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      checks++;
      if (mode_o[e.id] !== 2'(e.mode) || year_o[e.id] !== bcd4(e.y) ||
          month_o[e.id] !== bcd2(e.m) || day_o[e.id] !== bcd2(e.d) ||
          wrap_o[e.id] !== 1'(e.wrap)) begin
        failures++;
        $display("FAIL sb_state dut%0d: got mode=%0d date=%h-%h-%h wrap=%b, want mode=%0d date=%h-%h-%h wrap=%0d",
                 e.id, mode_o[e.id], year_o[e.id], month_o[e.id], day_o[e.id], wrap_o[e.id],
                 e.mode, bcd4(e.y), bcd2(e.m), bcd2(e.d), e.wrap);
      end
    end
  end

  // Walk instance id (in RUN) to the given date using the set buttons.
  task automatic set_date(input int id, input int y, input int m, input int d);
    cyc(id, 0, 1, 0);
    for (int k = 0; k < 300 && m_y[id] != y; k++) cyc(id, 0, 0, 1);
    cyc(id, 0, 1, 0);
    for (int k = 0; k < 12 && m_m[id] != m; k++) cyc(id, 0, 0, 1);
    cyc(id, 0, 1, 0);
    for (int k = 0; k < 31 && m_d[id] != d; k++) cyc(id, 0, 0, 1);
    cyc(id, 0, 1, 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    pulse_reset();
    for (int id = 0; id < 2; id++) begin
      checks++;
      if (mode_o[id] !== 2'd0 || year_o[id] !== 16'h2000 || month_o[id] !== 8'h01 ||
          day_o[id] !== 8'h01 || wrap_o[id] !== 1'b0) begin
        failures++;
        $display("FAIL reset_state dut%0d: got mode=%0d date=%h-%h-%h wrap=%b, want 0 2000-01-01 0",
                 id, mode_o[id], year_o[id], month_o[id], day_o[id], wrap_o[id]);
      end
      checks++;
      if (seg_o[id] !== 7'b0110000 || dpt_o[id] !== 1'b0) begin
        failures++;
        $display("FAIL reset_seg dut%0d: got seg=%b dpt=%b, want 0110000 0", id, seg_o[id], dpt_o[id]);
      end
    end
    checks++;
    if (sel_o[0] !== 3'd5 || sel_o[1] !== 3'd7) begin
      failures++;
      $display("FAIL reset_sel: got %0d/%0d, want 5/7", sel_o[0], sel_o[1]);
    end
  endtask

  task automatic test_reset_mid_set();
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    pulse_reset();
    checks++;
    if (mode_o[0] !== 2'd0 || year_o[0] !== 16'h2000) begin
      failures++;
      $display("FAIL reset_mid_set: got mode=%0d year=%h, want 0 2000", mode_o[0], year_o[0]);
    end
  endtask

  task automatic test_leap();
    set_date(0, 2024, 2, 28);
    cyc(0, 1, 0, 0);
    checks++;
    if (month_o[0] !== 8'h02 || day_o[0] !== 8'h29) begin
      failures++;
      $display("FAIL leap_2024_29: got %h-%h, want 02-29", month_o[0], day_o[0]);
    end
    cyc(0, 1, 0, 0);
    checks++;
    if (month_o[0] !== 8'h03 || day_o[0] !== 8'h01) begin
      failures++;
      $display("FAIL leap_2024_mar: got %h-%h, want 03-01", month_o[0], day_o[0]);
    end
    set_date(0, 2000, 2, 28);
    cyc(0, 1, 0, 0);
    checks++;
    if (year_o[0] !== 16'h2000 || day_o[0] !== 8'h29) begin
      failures++;
      $display("FAIL leap_2000_29: got %h day %h, want 2000 day 29", year_o[0], day_o[0]);
    end
    cyc(0, 1, 0, 0);
  endtask

  task automatic test_century();
    set_date(1, 2100, 2, 28);
    cyc(1, 1, 0, 0);
    checks++;
    if (year_o[1] !== 16'h2100 || month_o[1] !== 8'h03 || day_o[1] !== 8'h01) begin
      failures++;
      $display("FAIL century_2100: got %h-%h-%h, want 2100-03-01", year_o[1], month_o[1], day_o[1]);
    end
  endtask

  task automatic test_year_wrap();
    set_date(0, 2099, 12, 31);
    cyc(0, 1, 0, 0);
    checks++;
    if (wrap_o[0] !== 1'b1 || year_o[0] !== 16'h2000 || month_o[0] !== 8'h01 ||
        day_o[0] !== 8'h01) begin
      failures++;
      $display("FAIL year_wrap: got wrap=%b %h-%h-%h, want 1 2000-01-01",
               wrap_o[0], year_o[0], month_o[0], day_o[0]);
    end
    cyc(0, 0, 0, 0);
    checks++;
    if (wrap_o[0] !== 1'b0) begin
      failures++;
      $display("FAIL year_wrap_pulse: got %b, want 0", wrap_o[0]);
    end
  endtask

  task automatic test_clamp();
    set_date(0, 2023, 1, 31);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 1);
    checks++;
    if (month_o[0] !== 8'h02 || day_o[0] !== 8'h28) begin
      failures++;
      $display("FAIL clamp_feb: got %h-%h, want 02-28", month_o[0], day_o[0]);
    end
    cyc(0, 1, 0, 0);
    checks++;
    if (month_o[0] !== 8'h02 || day_o[0] !== 8'h28 || mode_o[0] !== 2'd2) begin
      failures++;
      $display("FAIL tick_in_set: got %h-%h mode %0d, want 02-28 mode 2",
               month_o[0], day_o[0], mode_o[0]);
    end
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
  endtask

  task automatic test_mode_inc_same();
    logic [15:0] y0;
    cyc(0, 0, 1, 0);
    y0 = year_o[0];
    cyc(0, 0, 1, 1);
    checks++;
    if (mode_o[0] !== 2'd2 || year_o[0] !== y0) begin
      failures++;
      $display("FAIL mode_and_inc: got mode=%0d year=%h, want 2 %h", mode_o[0], year_o[0], y0);
    end
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
  endtask

  task automatic test_tick_mode_run();
    cyc(0, 1, 1, 0);
    checks++;
    if (mode_o[0] !== 2'd1 || day_o[0] !== bcd2(m_d[0])) begin
      failures++;
      $display("FAIL tick_with_mode: got mode=%0d day=%h, want 1 %h", mode_o[0], day_o[0], bcd2(m_d[0]));
    end
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
  endtask

  task automatic test_scan();
    logic [2:0] prev;
    bit         synced;
    int         cnt, msel;
    set_date(1, 2187, 9, 25);
    synced = 1'b0;
    prev = sel_o[1];
    for (int k = 0; k < 8 && !synced; k++) begin
      @(posedge clk);
      #1;
      if (sel_o[1] !== prev) synced = 1'b1;
    end
    checks++;
    if (!synced) begin
      failures++;
      $display("FAIL scan_sync: sel stuck at %0d, want a change within 8 clocks", sel_o[1]);
    end
    cnt = 0;
    msel = int'(sel_o[1]);
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      cnt = (cnt + 1) % 4;
      if (cnt == 0) msel = (msel == 0) ? 7 : msel - 1;
      checks++;
      if (sel_o[1] !== 3'(msel) || seg_o[1] !== glyph(model_digit(1, msel)) ||
          dpt_o[1] !== ((msel == 3) || (msel == 5))) begin
        failures++;
        $display("FAIL scan_step %0d: got sel=%0d seg=%b dpt=%b, want sel=%0d seg=%b dpt=%b", k,
                 sel_o[1], seg_o[1], dpt_o[1], msel, glyph(model_digit(1, msel)),
                 (msel == 3) || (msel == 5));
      end
    end
  endtask

  task automatic test_blink();
    int year_blank, other_blank;
    cyc(1, 0, 1, 0);
    year_blank = 0;
    other_blank = 0;
    for (int k = 0; k < 1100; k++) begin
      @(posedge clk);
      #1;
      if (seg_o[1] === 7'b0000000) begin
        if (sel_o[1] < 3'd4) year_blank++;
        else other_blank++;
      end
    end
    checks++;
    if (other_blank != 0) begin
      failures++;
      $display("FAIL blink_other_fields: got %0d blank samples, want 0", other_blank);
    end
    checks++;
`ifdef CAL_BLINK_EN
    if (year_blank == 0) begin
      failures++;
      $display("FAIL blink_year: got 0 blank year samples, want >0");
    end
`else
    if (year_blank != 0) begin
      failures++;
      $display("FAIL blink_year: got %0d blank year samples, want 0", year_blank);
    end
`endif
    cyc(1, 0, 1, 0);
    cyc(1, 0, 1, 0);
    cyc(1, 0, 1, 0);
  endtask

  initial begin
    reset  = 1'b1;
    tick_v = '0;
    bm_v   = '0;
    bi_v   = '0;
    model_reset();
    test_reset();
    test_reset_mid_set();
    test_leap();
    test_century();
    test_year_wrap();
    test_clamp();
    test_mode_inc_same();
    test_tick_mode_run();
    test_scan();
    test_blink();
    @(negedge clk);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
